spu_hazard_ctrl: RTL
====================

// Module: spu_hazard_ctrl
// PURPOSE
//  Scoreboard-based hazard and pipeline-control unit for the SPU pipeline. Tracks pending writes to the
//  128x128-bit register file, decides each cycle whether the decoded instruction may issue, and drives
//  hold/flush controls for the PC, IF/ID and ID/EX stage registers. Branch/jump redirects resolved in EX
//  flush the younger stages. It also keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  NUM_REGS  128  register-file entries tracked by the scoreboard
//  ADDR_W    7    register address width (log2 NUM_REGS)
//  LAT_W     3    width of per-register countdown and of id_latency (max latency 2**LAT_W-1 = 7)
//  CNT_W     16   width of stall_cycles performance counter
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high
//  id_valid      in   1       ID stage holds a valid instruction
//  id_ra/rb/rc   in   ADDR_W  source register addresses
//  id_ra_rd      in   1       instruction reads ra (likewise id_rb_rd, id_rc_rd: 1 bit each)
//  id_rt         in   ADDR_W  destination register address
//  id_rt_wr      in   1       instruction writes rt
//  id_latency    in   LAT_W   cycles after issue until rt is forwardable (0 = available next cycle)
//  br_taken      in   1       EX resolved a taken branch/jump this cycle
//  issue         out  1       instruction in ID issues to EX this cycle
//  stall         out  1       ID held due to hazard
//  pc_hold       out  1       hold PC and IF/ID register (== stall)
//  ifid_flush    out  1       clear IF/ID register next edge
//  idex_flush    out  1       load bubble into ID/EX register next edge
//  busy_cnt      out  8       number of registers with pending writes (0..128)
//  stall_cycles  out  CNT_W   saturating count of cycles with stall=1
// BEHAVIOUR
//  - Reset (synchronous, active-high): on an edge with reset=1 all scoreboard counters cnt[0..127] <= 0
//    and stall_cycles <= 0. While reset=1, issue/stall/pc_hold/ifid_flush/idex_flush are forced to 0.
//    Reset mid-operation discards all pending entries; no partial-countdown state survives.
//  - Scoreboard: cnt[r] is LAT_W bits; busy(r) = (cnt[r] != 0). Hazard check uses registered cnt only.
//  - hazard = id_valid & ((id_ra_rd & busy(ra)) | (id_rb_rd & busy(rb)) | (id_rc_rd & busy(rc))
//                          | (id_rt_wr & busy(rt)))          // RAW on sources, WAW on rt
//  - Combinational outputs (same cycle as inputs, zero latency):
//      issue      = id_valid & ~hazard & ~br_taken
//      stall      = hazard & ~br_taken;  pc_hold = stall
//      ifid_flush = br_taken;  idex_flush = br_taken | stall
//  - br_taken has priority over stall: the ID instruction is killed (no issue, no scoreboard write),
//    stall=0. Entries from already-issued instructions are NOT cancelled and keep counting down.
//  - Counter update each edge (reset=0): every nonzero cnt[r] decrements by 1; then if issue & id_rt_wr
//    & (id_latency != 0), cnt[id_rt] <= id_latency (overrides decrement). Issue with latency 0 writes
//    nothing. WAW check guarantees cnt[id_rt]==0 whenever a write is loaded.
//  - Consequence: consumer of a latency-L producer issued at cycle t stalls exactly L cycles and issues
//    at t+L+1. A register with cnt==1 is still busy that cycle; it frees on the next edge.
//  - stall_cycles: +1 on each edge with stall=1; holds at 2**CNT_W-1 (no wrap).
//  - busy_cnt: combinational population count of busy(r) over all registers.
//  - id_valid=0: issue=0, stall=0, idex_flush=br_taken; counters still decrement.
// TESTING
//  1. Assert reset 2 cycles with id_valid=1 -> all control outputs 0, busy_cnt=0, stall_cycles=0 after.
//  2. Issue rt=5,lat=3 at t0; at t1 present ra=5,ra_rd=1 -> stall=1,idex_flush=1 at t1..t3, issue at t4,
//     stall_cycles=3.
//  3. Issue rt=9,lat=0; next cycle read rb=9 -> issue=1, stall=0, busy_cnt stays 0.
//  4. Issue rt=12,lat=7; next instr writes rt=12 (no source reads) -> WAW stall 7 cycles, then issue
//     and cnt[12] reloaded (busy_cnt=1).
//  5. During stall from (2), pulse br_taken -> issue=0, stall=0, ifid_flush=idex_flush=1,
//     stall_cycles unchanged; cnt[5] keeps decrementing.
//  6. Load rt=20,lat=7 and rt=21,lat=5, assert reset mid-countdown -> busy_cnt=0 next cycle and a
//     reader of r20 issues immediately; force stall for 65540 cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/spu_hazard_ctrl.sv
// Scoreboard hazard and pipeline-control unit for the SPU pipeline.
// Tracks pending register writes with per-register countdowns, gates issue
// on RAW/WAW hazards, and drives PC/IF-ID/ID-EX hold and flush controls.
module spu_hazard_ctrl #(
  parameter int unsigned NUM_REGS = 128,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_ra,
  input  logic [ADDR_W-1:0] id_rb,
  input  logic [ADDR_W-1:0] id_rc,
  input  logic              id_ra_rd,
  input  logic              id_rb_rd,
  input  logic              id_rc_rd,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rt_wr,
  input  logic [LAT_W-1:0]  id_latency,
  input  logic              br_taken,
  output logic              issue,
  output logic              stall,
  output logic              pc_hold,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [7:0]        busy_cnt,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                hazard;
  logic                sb_load;
  logic [CNT_W-1:0]    stall_cycles_q;
  logic [CNT_W-1:0]    stall_cycles_d;

  // Busy flags straight from the registered countdowns
  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  // RAW on any read source, WAW on the destination
  always_comb begin
    hazard = id_valid & ((id_ra_rd & busy[id_ra]) |
                         (id_rb_rd & busy[id_rb]) |
                         (id_rc_rd & busy[id_rc]) |
                         (id_rt_wr & busy[id_rt]));
  end

  // Issue/stall/flush controls; a taken branch kills the ID instruction
  always_comb begin
    issue      = 1'b0;
    stall      = 1'b0;
    pc_hold    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!reset) begin
      issue      = id_valid & ~hazard & ~br_taken;
      stall      = hazard & ~br_taken;
      pc_hold    = hazard & ~br_taken;
      ifid_flush = br_taken;
      idex_flush = br_taken | (hazard & ~br_taken);
    end
  end

  // Countdown all pending entries; a newly issued write overrides its slot
  always_comb begin
    sb_load = issue & id_rt_wr & (id_latency != '0);
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = busy[r] ? (cnt_q[r] - LAT_ONE) : '0;
      if (sb_load && (id_rt == ADDR_W'(r))) begin
        cnt_d[r] = id_latency;
      end
    end
  end

  // Saturating stall-cycle counter next state
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // Scoreboard and perf counter state; reset drops every pending entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Population count of busy registers
  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_cnt = busy_cnt + 8'(busy[r]);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
